// File: rtl/serial_subtractor_8_bits.sv
// serial_subtractor_8_bits
// Bit-serial, LSB-first subtractor: D = A - B - BIN over WIDTH clock cycles,
// with a START/BUSY/DONE handshake and borrow, zero and signed-overflow flags.
// One full-subtractor cell is reused for every bit position.
// Optional feature: define SERIAL_SUB_ADD_MODE_EN to add the OP input
// (OP=0 subtract, OP=1 add; BIN/BOUT then act as carry-in/carry-out).
module serial_subtractor_8_bits #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic             OP,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] D,
    output logic             BOUT,
    output logic             ZERO,
    output logic             OVF
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic             op_q, op_d;
`endif

    logic             a0, b0, bit_out, br_next, last_bit, ovf_next;
    logic [WIDTH-1:0] res_full;

    // Shared one-bit cell: difference/sum bit and next borrow/carry from the operand LSBs
    always_comb begin
        a0       = a_sh_q[0];
        b0       = b_sh_q[0];
        bit_out  = a0 ^ b0 ^ br_q;
        br_next  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
        res_full = {bit_out, res_q};
        ovf_next = (a_msb_q != b_msb_q) && (bit_out != a_msb_q);
`ifdef SERIAL_SUB_ADD_MODE_EN
        if (op_q) begin
            br_next  = (a0 & b0) | (a0 & br_q) | (b0 & br_q);
            ovf_next = (a_msb_q == b_msb_q) && (bit_out != a_msb_q);
        end
`endif
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

    // Next-state logic: capture on START in IDLE, one bit per cycle in RUN,
    // publish results only on the final bit so partial sums never reach D
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        d_d     = d_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
`ifdef SERIAL_SUB_ADD_MODE_EN
        op_d    = op_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    br_d    = BIN;
                    a_msb_d = A[WIDTH-1];
                    b_msb_d = B[WIDTH-1];
                    res_d   = '0;
                    cnt_d   = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
                    op_d    = OP;
`endif
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = br_next;
                res_d  = res_full[WIDTH-1:1];
                cnt_d  = cnt_q + CW'(1);
                if (last_bit) begin
                    d_d     = res_full;
                    bout_d  = br_next;
                    zero_d  = (res_full == '0);
                    ovf_d   = ovf_next;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            op_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
`ifdef SERIAL_SUB_ADD_MODE_EN
            op_q    <= op_d;
`endif
        end
    end

    assign BUSY = (state_q == ST_RUN);
    assign DONE = (state_q == ST_DONE);
    assign D    = d_q;
    assign BOUT = bout_q;
    assign ZERO = zero_q;
    assign OVF  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_8_bits.sv
// tb_serial_subtractor_8_bits
// Directed and randomized checks of serial_subtractor_8_bits against an
// arithmetic reference model. Add-mode cases run when SERIAL_SUB_ADD_MODE_EN is defined.
module tb_serial_subtractor_8_bits;

    localparam int WIDTH = 8;

    logic             CLK;
    logic             RST_N;
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BIN;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] D;
    logic             BOUT;
    logic             ZERO;
    logic             OVF;
    logic             opSel;

    int testsRun  = 0;
    int failCount = 0;
    logic [WIDTH-1:0] lastD = '0;

    serial_subtractor_8_bits #(.WIDTH(WIDTH)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
`ifdef SERIAL_SUB_ADD_MODE_EN
        .OP    (opSel),
`endif
        .A     (A),
        .B     (B),
        .BIN   (BIN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .D     (D),
        .BOUT  (BOUT),
        .ZERO  (ZERO),
        .OVF   (OVF)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Count one comparison and report it if observed differs from expected
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Plain-integer arithmetic model of the operation and its flags
    function automatic void referenceModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic bin, input logic op,
                                           output logic [WIDTH-1:0] d, output logic bo,
                                           output logic z, output logic ov);
        int r;
        if (op) begin
            r  = int'(a) + int'(b) + int'(bin);
            d  = r[WIDTH-1:0];
            bo = (r > 255);
            ov = (a[WIDTH-1] == b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
        end else begin
            r  = int'(a) - int'(b) - int'(bin);
            d  = r[WIDTH-1:0];
            bo = (r < 0);
            ov = (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
        end
        z = (d == '0);
    endfunction

    // Run one operation: pulse START, scramble inputs after capture, optionally
    // retrigger START mid-run, then check latency, results and the DONE pulse width
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic bin, input logic op, input bit midStart,
                                 input string tag);
        logic [WIDTH-1:0] expD;
        logic expB, expZ, expO;
        int busyCycles;
        bit gotDone;
        referenceModel(a, b, bin, op, expD, expB, expZ, expO);
        @(negedge CLK);
        A = a; B = b; BIN = bin; opSel = op; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        A = WIDTH'($urandom); B = WIDTH'($urandom); BIN = 1'($urandom); opSel = 1'($urandom);
        busyCycles = 0;
        gotDone = 1'b0;
        for (int i = 0; i < 3 * WIDTH; i++) begin
            if (DONE) begin
                gotDone = 1'b1;
                break;
            end
            if (BUSY) busyCycles++;
            if (i == 2) checkOutput({tag, "_dHoldInRun"}, 32'(D), 32'(lastD));
            if (midStart && i == 3) begin
                START = 1'b1;
                A = 8'h55;
            end
            if (midStart && i == 4) START = 1'b0;
            @(negedge CLK);
        end
        checkOutput({tag, "_done"}, 32'(gotDone), 32'd1);
        checkOutput({tag, "_busyCycles"}, 32'(busyCycles), 32'(WIDTH));
        checkOutput({tag, "_busyAtDone"}, 32'(BUSY), 32'd0);
        checkOutput({tag, "_d"}, 32'(D), 32'(expD));
        checkOutput({tag, "_bout"}, 32'(BOUT), 32'(expB));
        checkOutput({tag, "_zero"}, 32'(ZERO), 32'(expZ));
        checkOutput({tag, "_ovf"}, 32'(OVF), 32'(expO));
        @(negedge CLK);
        checkOutput({tag, "_donePulse"}, 32'(DONE), 32'd0);
        checkOutput({tag, "_dHoldAfter"}, 32'(D), 32'(expD));
        lastD = expD;
    endtask

    // Main sequence: reset state, directed cases, mid-run reset, random sweep
    initial begin
        bit sawDone;
        RST_N = 1'b1; START = 1'b0; A = '0; B = '0; BIN = 1'b0; opSel = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(BUSY), 32'd0);
        checkOutput("rst_done", 32'(DONE), 32'd0);
        checkOutput("rst_d", 32'(D), 32'd0);
        checkOutput("rst_flags", {29'd0, BOUT, ZERO, OVF}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, "t1");
        applyStimulus(8'hAE, 8'h26, 1'b0, 1'b0, 1'b0, "t2a");
        applyStimulus(8'h00, 8'h01, 1'b0, 1'b0, 1'b0, "t2b");
        applyStimulus(8'h80, 8'h01, 1'b0, 1'b0, 1'b0, "t3a");
        applyStimulus(8'h3C, 8'h3B, 1'b1, 1'b0, 1'b0, "t3b");
        applyStimulus(8'h10, 8'h01, 1'b0, 1'b0, 1'b1, "t4");

        @(negedge CLK);
        A = 8'h55; B = 8'h11; BIN = 1'b0; opSel = 1'b0; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        checkOutput("t5_busy", 32'(BUSY), 32'd0);
        checkOutput("t5_done", 32'(DONE), 32'd0);
        checkOutput("t5_d", 32'(D), 32'd0);
        checkOutput("t5_flags", {29'd0, BOUT, ZERO, OVF}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        sawDone = 1'b0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            @(negedge CLK);
            if (DONE) sawDone = 1'b1;
        end
        checkOutput("t5_noDone", 32'(sawDone), 32'd0);
        lastD = '0;
        applyStimulus(8'h55, 8'h11, 1'b0, 1'b0, 1'b0, "t5_after");

`ifdef SERIAL_SUB_ADD_MODE_EN
        applyStimulus(8'h88, 8'h26, 1'b0, 1'b1, 1'b0, "t6a");
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, "t6b");
        applyStimulus(8'h7F, 8'h01, 1'b0, 1'b1, 1'b0, "t6c");
`endif

        for (int n = 0; n < 40; n++) begin
            logic rop;
`ifdef SERIAL_SUB_ADD_MODE_EN
            rop = 1'($urandom);
`else
            rop = 1'b0;
`endif
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), rop,
                          1'($urandom_range(0, 3) == 0), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
